// File: rtl/hls_mem_harness.sv
// hls_mem_harness: on-chip memory emulator and run controller for an HLS core that uses the
// minimal Mout_*/M_* memory interface.
//
// Ports:
//   clk, reset         single clock, asynchronous active-low reset
//   start_port         one-cycle start pulse to the core
//   done_port          completion pulse from the core (only honoured in RUN)
//   Mout_*_ram         per-channel requests from the core (oe, we, addr, wdata, size in bits)
//   M_Rdata_ram        per-channel read data, zero when not ready
//   M_DataRdy          per-channel response strobe, LATENCY cycles after the request
//   pass               verdict of the last completed run
//   busy               high while the core is running
//   run_count          completed runs (wrapping)
//   fail_count         failed runs (saturating)
module hls_mem_harness #(
    parameter int unsigned                 CHANNELS      = 2,
    parameter int unsigned                 ADDR_W        = 32,
    parameter int unsigned                 DATA_W        = 32,
    parameter logic [ADDR_W-1:0]           IN_BASE       = ADDR_W'(32'h4000_0000),
    parameter int unsigned                 IN_WORDS      = 16,
    parameter logic [32*IN_WORDS-1:0]      IN_DATA       = (32*IN_WORDS)'('h80),
    parameter logic [ADDR_W-1:0]           OUT_BASE      = ADDR_W'(32'h4000_0200),
    parameter int unsigned                 OUT_WORDS     = 4,
    parameter logic [32*OUT_WORDS-1:0]     EXPECTED      =
        (32*OUT_WORDS)'(128'h0000_0083_0000_0082_0000_0081_0000_0080),
    parameter int unsigned                 LATENCY       = 1,
    parameter int unsigned                 RESTART_DELAY = 200,
    parameter int unsigned                 TIMEOUT       = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         start_port,
    input  logic                         done_port,
    input  logic [CHANNELS-1:0]          Mout_oe_ram,
    input  logic [CHANNELS-1:0]          Mout_we_ram,
    input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
    input  logic [CHANNELS*6-1:0]        Mout_data_ram_size,
    output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
    output logic [CHANNELS-1:0]          M_DataRdy,
    output logic                         pass,
    output logic                         busy,
    output logic [15:0]                  run_count,
    output logic [15:0]                  fail_count
);

    // ------------------------------------------------------------------
    // Per-channel request decode
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0]          req;
    logic [CHANNELS-1:0]          ch_bad;
    logic [OUT_WORDS-1:0]         ch_set [CHANNELS];
    logic [CHANNELS*DATA_W-1:0]   rd_data;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic                 oe, we, in_ok, out_ok, wr_ok;
        logic [ADDR_W-1:0]    addr, in_off, out_off;
        logic [DATA_W-1:0]    wdata, in_word, exp_word;
        logic [5:0]           size;
        logic [OUT_WORDS-1:0] out_hit;

        assign oe      = Mout_oe_ram[c];
        assign we      = Mout_we_ram[c];
        assign addr    = Mout_addr_ram[c*ADDR_W +: ADDR_W];
        assign wdata   = Mout_Wdata_ram[c*DATA_W +: DATA_W];
        assign size    = Mout_data_ram_size[c*6 +: 6];

        // Addresses below a base wrap to a huge index and fall out of the window.
        assign in_off  = addr - IN_BASE;
        assign out_off = addr - OUT_BASE;
        assign in_ok   = (addr[1:0] == 2'b00) && ((in_off >> 2) < ADDR_W'(IN_WORDS));
        assign out_ok  = (addr[1:0] == 2'b00) && ((out_off >> 2) < ADDR_W'(OUT_WORDS));

        always_comb begin
            in_word = '0;
            for (int i = 0; i < IN_WORDS; i++) begin
                if ((in_off >> 2) == ADDR_W'(i)) in_word = IN_DATA[32*i +: 32];
            end
        end

        always_comb begin
            exp_word = '0;
            out_hit  = '0;
            for (int i = 0; i < OUT_WORDS; i++) begin
                if (out_ok && ((out_off >> 2) == ADDR_W'(i))) begin
                    exp_word   = EXPECTED[32*i +: 32];
                    out_hit[i] = 1'b1;
                end
            end
        end

        assign wr_ok     = we && out_ok && (size == 6'd32);
        assign req[c]    = oe | we;
        assign ch_set[c] = wr_ok ? out_hit : '0;
        // oe together with we is executed as a write but always counts as a protocol error.
        assign ch_bad[c] = we && (!wr_ok || (wdata != exp_word) || oe);
        assign rd_data[c*DATA_W +: DATA_W] = (oe && !we && in_ok) ? in_word : '0;
    end

    logic [OUT_WORDS-1:0] wr_set;
    always_comb begin
        wr_set = '0;
        for (int c = 0; c < CHANNELS; c++) wr_set = wr_set | ch_set[c];
    end

    // ------------------------------------------------------------------
    // Response pipeline: stage 0 is loaded at the request edge
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0]        rdy_q [LATENCY];
    logic [CHANNELS*DATA_W-1:0] dat_q [LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                rdy_q[s] <= '0;
                dat_q[s] <= '0;
            end
        end else begin
            rdy_q[0] <= req;
            dat_q[0] <= rd_data;
            for (int s = 1; s < LATENCY; s++) begin
                rdy_q[s] <= rdy_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign M_DataRdy   = rdy_q[LATENCY-1];
    assign M_Rdata_ram = dat_q[LATENCY-1];

    // ------------------------------------------------------------------
    // Run FSM and scoring
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StWait, StStart, StRun, StCheck} state_e;

    state_e               state_q;
    logic [31:0]          delay_q;
    logic [31:0]          run_cnt_q;
    logic                 timeout_q;
    logic                 mismatch_q;
    logic [OUT_WORDS-1:0] written_q;
    logic                 start_q;
    logic                 busy_q;
    logic                 pass_q;
    logic [15:0]          run_count_q;
    logic [15:0]          fail_count_q;
    logic                 verdict;

    assign verdict = (&written_q) & ~mismatch_q & ~timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StWait;
            delay_q      <= '0;
            run_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            written_q    <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            pass_q       <= 1'b0;
            run_count_q  <= '0;
            fail_count_q <= '0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                StWait: begin
                    if (delay_q == '0) begin
                        state_q <= StStart;
                        start_q <= 1'b1;
                    end else begin
                        delay_q <= delay_q - 32'd1;
                    end
                end
                StStart: begin
                    written_q  <= '0;
                    mismatch_q <= 1'b0;
                    timeout_q  <= 1'b0;
                    run_cnt_q  <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= StRun;
                end
                StRun: begin
                    // Writes are scored at the request edge, including one coincident with done.
                    written_q  <= written_q | wr_set;
                    mismatch_q <= mismatch_q | (|ch_bad);
                    if (done_port) begin
                        busy_q  <= 1'b0;
                        state_q <= StCheck;
                    end else if (run_cnt_q == 32'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StCheck;
                    end else begin
                        run_cnt_q <= run_cnt_q + 32'd1;
                    end
                end
                StCheck: begin
                    pass_q      <= verdict;
                    run_count_q <= run_count_q + 16'd1;
                    if (!verdict && (fail_count_q != 16'hFFFF)) begin
                        fail_count_q <= fail_count_q + 16'd1;
                    end
                    delay_q <= 32'(RESTART_DELAY - 1);
                    state_q <= StWait;
                end
                default: state_q <= StWait;
            endcase
        end
    end

    assign start_port = start_q;
    assign busy       = busy_q;
    assign pass       = pass_q;
    assign run_count  = run_count_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_hls_mem_harness.sv
// Bench for hls_mem_harness: instance A uses the default timing, instance B uses LATENCY=3,
// TIMEOUT=50, RESTART_DELAY=20. Only one instance is out of reset at a time; they share the
// request inputs and a response scoreboard.
module tb_hls_mem_harness;

    localparam logic [31:0]  IB  = 32'h4000_0000;
    localparam logic [31:0]  OB  = 32'h4000_0200;
    localparam logic [31:0]  E0  = 32'h1111_2222;
    localparam logic [31:0]  E1  = 32'hDEAD_BEEF;
    localparam logic [31:0]  E2  = 32'h0F0F_A5A5;
    localparam logic [31:0]  E3  = 32'h8000_0001;
    localparam logic [127:0] EXP = {E3, E2, E1, E0};

    function automatic logic [31:0] inb(input int i);
        return 32'hC0DE_0000 + 32'(i * 4369);
    endfunction

    function automatic logic [511:0] mk_in_b();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = inb(i);
        return v;
    endfunction

    localparam logic [511:0] IN_B = mk_in_b();

    logic        clk = 1'b0;
    logic        rst_a, rst_b, done, sel;
    logic [1:0]  oe, we;
    logic [63:0] addr, wdata;
    logic [11:0] size;

    logic        start_a, pass_a, busy_a, start_b, pass_b, busy_b;
    logic [1:0]  rdy_a, rdy_b;
    logic [63:0] rdata_a, rdata_b;
    logic [15:0] run_a, fail_a, run_b, fail_b;

    always #5 clk = ~clk;

    hls_mem_harness #(
        .CHANNELS (2),
        .EXPECTED (EXP)
    ) u_a (
        .clk(clk), .reset(rst_a), .start_port(start_a), .done_port(done),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata),
        .Mout_data_ram_size(size), .M_Rdata_ram(rdata_a), .M_DataRdy(rdy_a),
        .pass(pass_a), .busy(busy_a), .run_count(run_a), .fail_count(fail_a)
    );

    hls_mem_harness #(
        .CHANNELS      (2),
        .IN_DATA       (IN_B),
        .EXPECTED      (EXP),
        .LATENCY       (3),
        .RESTART_DELAY (20),
        .TIMEOUT       (50)
    ) u_b (
        .clk(clk), .reset(rst_b), .start_port(start_b), .done_port(done),
        .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr), .Mout_Wdata_ram(wdata),
        .Mout_data_ram_size(size), .M_Rdata_ram(rdata_b), .M_DataRdy(rdy_b),
        .pass(pass_b), .busy(busy_b), .run_count(run_b), .fail_count(fail_b)
    );

    logic        start_m, pass_m, busy_m;
    logic [1:0]  rdy_m;
    logic [63:0] rdata_m;
    logic [15:0] run_m, fail_m;
    assign start_m = sel ? start_b : start_a;
    assign pass_m  = sel ? pass_b  : pass_a;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign rdy_m   = sel ? rdy_b   : rdy_a;
    assign rdata_m = sel ? rdata_b : rdata_a;
    assign run_m   = sel ? run_b   : run_a;
    assign fail_m  = sel ? fail_b  : fail_a;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- stimulus records ----------------
    typedef struct packed {
        logic        oe;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [5:0]  s;
        logic [31:0] r;   // expected response data
    } op_t;

    typedef struct packed {
        op_t  c0;
        op_t  c1;
        logic done;
    } vec_t;

    function automatic op_t nop();
        return '0;
    endfunction
    function automatic op_t rd(input logic [31:0] a, input logic [31:0] r);
        op_t o = '0;
        o.oe = 1'b1; o.a = a; o.s = 6'd32; o.r = r;
        return o;
    endfunction
    function automatic op_t wrs(input logic [31:0] a, input logic [31:0] d, input logic [5:0] s);
        op_t o = '0;
        o.we = 1'b1; o.a = a; o.d = d; o.s = s;
        return o;
    endfunction
    function automatic op_t wr(input logic [31:0] a, input logic [31:0] d);
        return wrs(a, d, 6'd32);
    endfunction
    function automatic op_t rw(input logic [31:0] a, input logic [31:0] d);
        op_t o = wrs(a, d, 6'd32);
        o.oe = 1'b1;
        return o;
    endfunction
    function automatic vec_t mkv(input op_t c0, input op_t c1, input logic dn);
        vec_t x;
        x.c0 = c0; x.c1 = c1; x.done = dn;
        return x;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } sb_t;
    sb_t q0[$];
    sb_t q1[$];

    task automatic drive(input vec_t v);
        int unsigned lat = sel ? 3 : 1;
        oe    = {v.c1.oe, v.c0.oe};
        we    = {v.c1.we, v.c0.we};
        addr  = {v.c1.a, v.c0.a};
        wdata = {v.c1.d, v.c0.d};
        size  = {v.c1.s, v.c0.s};
        done  = v.done;
        if (v.c0.oe | v.c0.we) q0.push_back({cyc + lat, v.c0.r});
        if (v.c1.oe | v.c1.we) q1.push_back({cyc + lat, v.c1.r});
    endtask

    task automatic mon_ch(input int ch, input logic rdy, input logic [31:0] d);
        sb_t e;
        int  n;
        if (!rdy) begin
            if (d !== 32'h0) chk($sformatf("rdata_idle_ch%0d", ch), d, 32'h0);
            return;
        end
        n = (ch == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rdy_ch%0d: got DataRdy=1, want 0 (cycle %0d)", ch, cyc);
            return;
        end
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("rdata_ch%0d", ch), d, e.data);
        chk($sformatf("rdy_cycle_ch%0d", ch), cyc, e.due);
    endtask

    always @(negedge clk) begin
        mon_ch(0, rdy_m[0], rdata_m[31:0]);
        mon_ch(1, rdy_m[1], rdata_m[63:32]);
    end

    task automatic wait_start(input int budget);
        int n = 0;
        while (!start_m && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!start_m) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_start: got no start_port, want one within %0d cycles", budget);
        end
    endtask

    // ---------------- run table for instance A ----------------
    localparam int NRUNS = 8;
    vec_t        vecs     [4*NRUNS];
    logic        exp_pass [NRUNS];
    logic [15:0] exp_fail [NRUNS];

    task automatic set_run(input int r, input vec_t v0, input vec_t v1, input vec_t v2,
                           input vec_t v3, input logic p, input logic [15:0] f);
        vecs[4*r] = v0; vecs[4*r+1] = v1; vecs[4*r+2] = v2; vecs[4*r+3] = v3;
        exp_pass[r] = p;
        exp_fail[r] = f;
    endtask

    initial begin
        vec_t r_v0, w01, idle, w23;
        int unsigned s, c;
        int n;

        idle = mkv(nop(), nop(), 1'b0);
        r_v0 = mkv(rd(IB, 32'h80), rd(IB + 4, 32'h0), 1'b0);
        w01  = mkv(wr(OB, E0), wr(OB + 4, E1), 1'b0);
        w23  = mkv(wr(OB + 8, E2), wr(OB + 12, E3), 1'b1);   // last writes with done
        set_run(0, r_v0, w01, idle, w23, 1'b1, 16'd0);
        set_run(1, r_v0, w01, idle, mkv(wr(OB + 8, E2 ^ 32'h1), wr(OB + 12, E3), 1'b1),
                1'b0, 16'd1);
        set_run(2, r_v0, w01, idle, w23, 1'b1, 16'd1);
        set_run(3, r_v0, w01, idle, mkv(wr(OB + 8, E2), nop(), 1'b1), 1'b0, 16'd2);
        set_run(4, r_v0, w01, mkv(wr(OB + 2, E0), nop(), 1'b0), w23, 1'b0, 16'd3);
        set_run(5, r_v0, w01, mkv(wrs(OB, E0, 6'd8), nop(), 1'b0), w23, 1'b0, 16'd4);
        set_run(6, r_v0, w01, mkv(rw(OB, E0), nop(), 1'b0), w23, 1'b0, 16'd5);
        set_run(7, mkv(rd(OB, 32'h0), rd(IB + 64, 32'h0), 1'b0),
                mkv(wr(OB, E0), wr(OB, E0), 1'b0),
                mkv(wr(OB + 4, E1), wr(OB + 8, E2), 1'b0),
                mkv(wr(OB + 12, E3), nop(), 1'b1), 1'b1, 16'd5);

        sel   = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        drive(idle);
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_start_a", {31'h0, start_a}, 32'h0);
        chk("rst_rdy_a", {30'h0, rdy_a}, 32'h0);
        chk("rst_rdata_a", rdata_a[31:0] | rdata_a[63:32], 32'h0);
        chk("rst_pass_a", {31'h0, pass_a}, 32'h0);
        chk("rst_busy_a", {31'h0, busy_a}, 32'h0);
        chk("rst_run_a", {16'h0, run_a}, 32'h0);
        chk("rst_fail_a", {16'h0, fail_a}, 32'h0);
        chk("rst_start_b", {31'h0, start_b}, 32'h0);

        // Instance A: table-driven runs
        rst_a = 1'b1;
        @(negedge clk);
        chk("start_after_release_a", {31'h0, start_m}, 32'h1);
        for (int r = 0; r < NRUNS; r++) begin
            if (r > 0) wait_start(300);
            @(negedge clk);
            chk($sformatf("start_one_cycle_r%0d", r), {31'h0, start_m}, 32'h0);
            chk($sformatf("busy_run_r%0d", r), {31'h0, busy_m}, 32'h1);
            for (int k = 0; k < 4; k++) begin
                drive(vecs[4*r+k]);
                @(negedge clk);
            end
            drive(idle);
            @(negedge clk);
            chk($sformatf("pass_r%0d", r), {31'h0, pass_m}, {31'h0, exp_pass[r]});
            chk($sformatf("run_count_r%0d", r), {16'h0, run_m}, 32'(r + 1));
            chk($sformatf("fail_count_r%0d", r), {16'h0, fail_m}, {16'h0, exp_fail[r]});
        end

        // Instance B: latency 3, timeout, restart gap
        rst_a = 1'b0;
        sel   = 1'b1;
        @(negedge clk);
        chk("sb_empty_after_a", 32'(q0.size() + q1.size()), 32'h0);
        rst_b = 1'b1;
        @(negedge clk);
        chk("start_after_release_b", {31'h0, start_m}, 32'h1);
        s = cyc;
        @(negedge clk);
        chk("busy_run_b", {31'h0, busy_m}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(mkv(rd(IB + 32'(4 * i), inb(i)), rd(IB + 32'(4 * (i + 4)), inb(i + 4)), 1'b0));
            @(negedge clk);
        end
        drive(mkv(rd(IB + 64, 32'h0), rd(IB + 60, inb(15)), 1'b0));
        @(negedge clk);
        drive(idle);
        n = 0;
        while (busy_m && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_check_cycle", cyc, s + 51);
        c = cyc;
        @(negedge clk);
        chk("timeout_pass", {31'h0, pass_m}, 32'h0);
        chk("timeout_run_count", {16'h0, run_m}, 32'h1);
        chk("timeout_fail_count", {16'h0, fail_m}, 32'h1);
        // done while waiting must be ignored
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        wait_start(50);
        chk("restart_gap", cyc, c + 21);
        chk("done_in_wait_ignored", {16'h0, run_m}, 32'h1);

        // done in START is ignored, then reset with a read in flight
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("done_in_start_ignored", {31'h0, busy_m}, 32'h1);
        drive(mkv(rd(IB + 8, inb(2)), nop(), 1'b0));
        @(negedge clk);
        drive(idle);
        rst_b = 1'b0;
        #1;
        chk("midrst_start", {31'h0, start_b}, 32'h0);
        chk("midrst_rdy", {30'h0, rdy_b}, 32'h0);
        chk("midrst_rdata", rdata_b[31:0] | rdata_b[63:32], 32'h0);
        chk("midrst_busy", {31'h0, busy_b}, 32'h0);
        chk("midrst_run_count", {16'h0, run_b}, 32'h0);
        chk("midrst_fail_count", {16'h0, fail_b}, 32'h0);
        chk("midrst_pending", 32'(q0.size()), 32'h1);
        q0.delete();
        q1.delete();
        repeat (4) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("start_after_midrst", {31'h0, start_m}, 32'h1);
        @(negedge clk);
        chk("start_one_cycle_midrst", {31'h0, start_m}, 32'h0);
        repeat (6) @(negedge clk);
        chk("sb_empty_end", 32'(q0.size() + q1.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hls_mem_harness.md
# hls_mem_harness

Parametrised on-chip memory emulator and self-checking run controller for Bambu-generated HLS cores that use the `Mout_*`/`M_*` minimal memory interface. It serves reads from a parameter-initialised input window and captures writes into an output window, comparing them word-by-word against an expected result. It pulses `start_port`, watches `done_port`, and issues a pass/fail verdict per run. It restarts the core after a programmable delay, and sits in the board top level between the HLS core and the status LEDs and logic-analyser header.

## Interface

Parameters:
- CHANNELS, 2, number of memory ports on the core (1..4).
- ADDR_W, 32, per-channel byte address width.
- DATA_W, 32, per-channel data width; only 32 is supported.
- IN_BASE, 32'h40000000, byte base of the read-only input window.
- IN_WORDS, 16, input window size in 32-bit words.
- IN_DATA, 512'h80, flat input contents; word i is `IN_DATA[32*i +: 32]`.
- OUT_BASE, 32'h40000200, byte base of the output window.
- OUT_WORDS, 4, output window size in words (1..16).
- EXPECTED, 128'h…, flat expected output; word i is `EXPECTED[32*i +: 32]`.
- LATENCY, 1, request-to-response cycles (1..4).
- RESTART_DELAY, 200, idle cycles between runs (≥1).
- TIMEOUT, 65535, maximum RUN cycles before a forced fail.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- start_port  out  1  start pulse to the core.
- done_port  in  1  completion pulse from the core.
- Mout_oe_ram  in  CHANNELS  per-channel read request.
- Mout_we_ram  in  CHANNELS  per-channel write request.
- Mout_addr_ram  in  CHANNELS*ADDR_W  per-channel byte address.
- Mout_Wdata_ram  in  CHANNELS*DATA_W  per-channel write data.
- Mout_data_ram_size  in  CHANNELS*6  per-channel access size in bits.
- M_Rdata_ram  out  CHANNELS*DATA_W  per-channel read data.
- M_DataRdy  out  CHANNELS  per-channel response strobe.
- pass  out  1  sticky verdict of the last completed run.
- busy  out  1  high while in RUN.
- run_count  out  16  completed runs, wrapping.
- fail_count  out  16  failed runs, saturating at 16'hFFFF.

## Operation

- **Request decoding.** A request on channel c is `oe[c] | we[c]`. Each channel is independent and fully pipelined: one request per cycle per channel.
- **Word index.** Computed as `(addr - BASE) >> 2`. An access is in-window only if `addr[1:0] == 0` and index < WORDS.
- **Reads.**
  - In the input window: return `IN_DATA` word.
  - Anywhere else, including the output window: return 0.
- **Writes.**
  - Valid only if in the output window and size == 32.
  - A valid write sets `written[idx]`. If the data ≠ EXPECTED word idx, it sets `mismatch`.
  - Any other write, and any request with `oe[c] & we[c]` (executed as a write), sets `mismatch`.
- **Multi-channel writes.** Writes to the same index on several channels in one cycle are each compared; `written[idx]` is set once.
- **Run FSM.**
  - WAIT: counter counts down; on reaching 0 → START.
  - START: `start_port` = 1 for exactly one cycle; `written` and `mismatch` cleared; RUN cycle counter cleared → RUN.
  - RUN: on `done_port` → CHECK. If the RUN counter reaches TIMEOUT with no `done_port` → CHECK with a forced fail.
  - CHECK (one cycle): verdict = `&written & ~mismatch & ~timeout`. Then `pass` ← verdict, `run_count` += 1, and `fail_count` += 1 (saturating) if the verdict fails. Counter loaded with RESTART_DELAY-1 → WAIT.
- `done_port` outside RUN is ignored.
- Memory requests outside RUN are still answered but are not scored.

## Timing

- **Reset values.**
  - `start_port`=0, `M_DataRdy`=0, `M_Rdata_ram`=0, `pass`=0, `busy`=0, `run_count`=0, `fail_count`=0.
  - All pipeline stages empty.
  - State WAIT with counter=0, so `start_port` pulses on the second rising edge after reset release.
- **Response timing.** A request sampled at edge t produces `M_DataRdy[c]`=1 for one cycle after edge t+LATENCY-1. For LATENCY=1 this is the cycle after the request.
  - `M_Rdata_ram` is valid in the same cycle and is 0 when not ready.
  - Writes are also acknowledged, using the same latency.
- **Scoring.** Write comparison happens at the request edge, not the response edge.
- **`done_port` timing.**
  - `done_port` in the START cycle is ignored.
  - `done_port` in the same cycle as a final write is valid: that write is scored before CHECK.
- **Back-to-back runs.** The gap from CHECK to the next `start_port` is RESTART_DELAY cycles.
- **Reset mid-run.** An asynchronous reset assertion mid-run aborts immediately: outputs go to their reset values and in-flight responses are dropped.

## Test plan

1. Defaults, model core reads word 0 then writes EXPECTED words 0..3 on channels 0/1 → word 0 read returns 32'h00000080 with `M_DataRdy` 1 cycle later; on done, `pass`=1, `run_count`=1, `fail_count`=0.
2. Same run with EXPECTED word 2 corrupted by one bit → `pass`=0, `fail_count`=1; next run correct → `pass`=1, `fail_count` remains 1.
3. Core omits the write to word 3 → fail. Core writes to OUT_BASE+2 (unaligned) or with size 8 → fail.
4. LATENCY=3, four back-to-back reads on both channels → four consecutive `DataRdy` pulses starting 3 cycles after the first request, with data in order; read of IN_BASE+64 → 0.
5. TIMEOUT=50, core never asserts done → CHECK at RUN cycle 50, `fail_count`=1, next `start_port` RESTART_DELAY cycles later.
6. Reset asserted mid-RUN with a read in flight → all outputs 0 immediately, no `DataRdy`; after release, `start_port` pulses at the second edge.
